// File: rtl/bank_pkg.sv
// rtl/bank_pkg.sv - shared widths and request struct for the bank request path
package bank_pkg;

  localparam int CH_ID_W   = 2;
  localparam int OPCODE_W  = 2;
  localparam int ADDR_HI   = 31;
  localparam int ADDR_LO   = 4;
  localparam int WBUF_ID_W = 8;
  localparam int ADDR_W    = ADDR_HI - ADDR_LO + 1;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [ADDR_W-1:0]    addr;
    logic [WBUF_ID_W-1:0] wbuffer_id;
  } bank_req_t;

  localparam int REQ_W = $bits(bank_req_t);

endpackage

// File: rtl/bank_xbar_arb_if.sv
// rtl/bank_xbar_arb_if.sv - channel request, HTU request and credit-return signals of bank_xbar_arb
interface bank_xbar_arb_if #(parameter int NUM_CH = 4);
  import bank_pkg::*;

  logic [NUM_CH-1:0]           ch_req_valid_i;
  logic [NUM_CH-1:0]           ch_req_ready_o;
  logic [OPCODE_W*NUM_CH-1:0]  ch_req_opcode_i;
  logic [ADDR_W*NUM_CH-1:0]    ch_req_addr_i;
  logic [WBUF_ID_W*NUM_CH-1:0] ch_req_wbuffer_id_i;

  logic                 arb_htu_valid_o;
  logic                 arb_htu_ready_i;
  logic [CH_ID_W-1:0]   arb_htu_ch_id_o;
  logic [OPCODE_W-1:0]  arb_htu_opcode_o;
  logic [ADDR_W-1:0]    arb_htu_addr_o;
  logic [WBUF_ID_W-1:0] arb_htu_wbuffer_id_o;

  logic                 xbar_rtn_valid_i;
  logic [CH_ID_W-1:0]   xbar_rtn_ch_id_i;
  logic [NUM_CH-1:0]    ch_credit_zero_o;
  logic                 credit_err_o;

  modport slave (
    input  ch_req_valid_i, ch_req_opcode_i, ch_req_addr_i, ch_req_wbuffer_id_i,
    input  arb_htu_ready_i, xbar_rtn_valid_i, xbar_rtn_ch_id_i,
    output ch_req_ready_o, arb_htu_valid_o, arb_htu_ch_id_o, arb_htu_opcode_o,
    output arb_htu_addr_o, arb_htu_wbuffer_id_o, ch_credit_zero_o, credit_err_o
  );

  modport master (
    output ch_req_valid_i, ch_req_opcode_i, ch_req_addr_i, ch_req_wbuffer_id_i,
    output arb_htu_ready_i, xbar_rtn_valid_i, xbar_rtn_ch_id_i,
    input  ch_req_ready_o, arb_htu_valid_o, arb_htu_ch_id_o, arb_htu_opcode_o,
    input  arb_htu_addr_o, arb_htu_wbuffer_id_o, ch_credit_zero_o, credit_err_o
  );

endinterface

// File: rtl/bank_xbar_arb_fifo.sv
// rtl/bank_xbar_arb_fifo.sv - per-channel sync FIFO, power-of-two depth
module bank_xbar_arb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/bank_xbar_arb.sv
// rtl/bank_xbar_arb.sv - round-robin request arbiter with per-channel credits in front of bank_htu
// Optional credit scheduling is enabled by defining BANK_XBAR_ARB_CREDIT_EN.
module bank_xbar_arb
  import bank_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int CREDITS    = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  bank_xbar_arb_if.slave  bus
);

  localparam int CRED_W = $clog2(CREDITS + 1);

  bank_req_t         fifo_din  [NUM_CH];
  bank_req_t         fifo_dout [NUM_CH];
  logic [NUM_CH-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop, eligible;

  logic               grant_vld;
  logic [CH_ID_W-1:0] grant_id;
  logic               load_ok;
  logic [CH_ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic               out_valid_q;
  logic [CH_ID_W-1:0] out_ch_q;
  bank_req_t          out_req_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign fifo_din[k] = {bus.ch_req_opcode_i[OPCODE_W*k +: OPCODE_W],
                          bus.ch_req_addr_i[ADDR_W*k +: ADDR_W],
                          bus.ch_req_wbuffer_id_i[WBUF_ID_W*k +: WBUF_ID_W]};
    assign fifo_push[k] = bus.ch_req_valid_i[k] && !fifo_full[k];
    assign fifo_pop[k]  = grant_vld && (grant_id == CH_ID_W'(k));

    bank_xbar_arb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REQ_W)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push[k]),
      .pop_i   (fifo_pop[k]),
      .din_i   (fifo_din[k]),
      .dout_o  (fifo_dout[k]),
      .full_o  (fifo_full[k]),
      .empty_o (fifo_empty[k])
    );
  end

  assign bus.ch_req_ready_o = ~fifo_full;

`ifdef BANK_XBAR_ARB_CREDIT_EN
  logic [CRED_W-1:0] credit_q [NUM_CH];
  logic [CRED_W-1:0] credit_d [NUM_CH];
  logic [NUM_CH-1:0] rtn_hit;
  logic              err_q, err_d;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cred
    assign rtn_hit[k]  = bus.xbar_rtn_valid_i && (bus.xbar_rtn_ch_id_i == CH_ID_W'(k));
    assign eligible[k] = !fifo_empty[k] && (credit_q[k] != '0);
    assign bus.ch_credit_zero_o[k] = (credit_q[k] == '0);
  end

  // A grant and a return on the same channel cancel; a return at full credit saturates and flags.
  always_comb begin
    err_d = err_q;
    for (int k = 0; k < NUM_CH; k++) begin
      credit_d[k] = credit_q[k];
      if (fifo_pop[k] && !rtn_hit[k]) begin
        credit_d[k] = credit_q[k] - CRED_W'(1);
      end else if (rtn_hit[k] && !fifo_pop[k]) begin
        if (credit_q[k] == CRED_W'(CREDITS)) err_d = 1'b1;
        else                                 credit_d[k] = credit_q[k] + CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) credit_q[k] <= CRED_W'(CREDITS);
    end else begin
      err_q <= err_d;
      for (int k = 0; k < NUM_CH; k++) credit_q[k] <= credit_d[k];
    end
  end

  assign bus.credit_err_o = err_q;
`else
  logic unused_rtn;

  assign unused_rtn           = ^{bus.xbar_rtn_valid_i, bus.xbar_rtn_ch_id_i};
  assign eligible             = ~fifo_empty;
  assign bus.ch_credit_zero_o = '0;
  assign bus.credit_err_o     = 1'b0;
`endif

  assign load_ok = !out_valid_q || bus.arb_htu_ready_i;

  // First eligible channel starting at rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    logic [CH_ID_W:0] sum;
    grant_vld = 1'b0;
    grant_id  = '0;
    sum       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, rr_ptr_q} + (CH_ID_W+1)'(i);
      if (sum >= (CH_ID_W+1)'(NUM_CH)) sum = sum - (CH_ID_W+1)'(NUM_CH);
      if (!grant_vld && load_ok && eligible[sum[CH_ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = sum[CH_ID_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_id == CH_ID_W'(NUM_CH-1)) ? '0 : grant_id + CH_ID_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_req_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (load_ok) begin
        out_valid_q <= grant_vld;
        if (grant_vld) begin
          out_ch_q  <= grant_id;
          out_req_q <= fifo_dout[grant_id];
        end
      end
    end
  end

  assign bus.arb_htu_valid_o      = out_valid_q;
  assign bus.arb_htu_ch_id_o      = out_ch_q;
  assign bus.arb_htu_opcode_o     = out_req_q.opcode;
  assign bus.arb_htu_addr_o       = out_req_q.addr;
  assign bus.arb_htu_wbuffer_id_o = out_req_q.wbuffer_id;

endmodule

// File: tb/tb_bank_xbar_arb.sv
// tb/tb_bank_xbar_arb.sv - directed-vector bench for bank_xbar_arb (credit or no-credit build)
module tb_bank_xbar_arb;
  import bank_pkg::*;

  localparam int NUM_CH = 4;
`ifdef BANK_XBAR_ARB_CREDIT_EN
  localparam bit CRED_EN = 1'b1;
`else
  localparam bit CRED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   miscmp_cnt = 0;
  int   cnt  [NUM_CH];
  int   gcnt [NUM_CH];
  bit   acc  [NUM_CH];
  int   grants;
  int   exp_ch;

  always #5 clk = ~clk;

  bank_xbar_arb_if #(.NUM_CH(NUM_CH)) bus ();

  bank_xbar_arb #(.NUM_CH(NUM_CH), .FIFO_DEPTH(2), .CREDITS(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic expect_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ch_req_valid_i      = '0;
    bus.ch_req_opcode_i     = '0;
    bus.ch_req_addr_i       = '0;
    bus.ch_req_wbuffer_id_i = '0;
    bus.arb_htu_ready_i     = 1'b1;
    bus.xbar_rtn_valid_i    = 1'b0;
    bus.xbar_rtn_ch_id_i    = '0;
  endtask

  task automatic set_req(input int k, input logic [1:0] opc, input logic [27:0] addr, input logic [7:0] wb);
    bus.ch_req_opcode_i[OPCODE_W*k +: OPCODE_W]      = opc;
    bus.ch_req_addr_i[ADDR_W*k +: ADDR_W]            = addr;
    bus.ch_req_wbuffer_id_i[WBUF_ID_W*k +: WBUF_ID_W] = wb;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Stream n_req requests on channel k (addr = base + seq) and count grants seen on the HTU side.
  task automatic run_stream(input int k, input int n_req, input int cycles, input int base, output int g);
    int  c_acc;
    bit  a;
    c_acc = 0;
    g     = 0;
    for (int c = 0; c < cycles; c++) begin
      if (bus.arb_htu_valid_o && bus.arb_htu_ch_id_o == CH_ID_W'(k)) begin
        expect_eq("stream_addr", bus.arb_htu_addr_o, base + g);
        g++;
      end
      bus.ch_req_valid_i[k] = (c_acc < n_req);
      set_req(k, 2'd0, 28'(base + c_acc), 8'h00);
      a = bus.ch_req_valid_i[k] && bus.ch_req_ready_o[k];
      step();
      if (a) c_acc++;
    end
    bus.ch_req_valid_i[k] = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state
    expect_eq("rst_valid", bus.arb_htu_valid_o, 0);
    expect_eq("rst_ready", bus.ch_req_ready_o, 4'hf);
    expect_eq("rst_ch_id", bus.arb_htu_ch_id_o, 0);
    expect_eq("rst_addr", bus.arb_htu_addr_o, 0);
    expect_eq("rst_zero", bus.ch_credit_zero_o, 0);
    expect_eq("rst_err", bus.credit_err_o, 0);

    // Single request, two-cycle latency
    bus.ch_req_valid_i[2] = 1'b1;
    set_req(2, 2'd1, 28'h0ABCDEF, 8'h33);
    step();
    bus.ch_req_valid_i[2] = 1'b0;
    expect_eq("single_n1_valid", bus.arb_htu_valid_o, 0);
    step();
    expect_eq("single_valid", bus.arb_htu_valid_o, 1);
    expect_eq("single_ch", bus.arb_htu_ch_id_o, 2);
    expect_eq("single_opc", bus.arb_htu_opcode_o, 1);
    expect_eq("single_addr", bus.arb_htu_addr_o, 28'h0ABCDEF);
    expect_eq("single_wbuf", bus.arb_htu_wbuffer_id_o, 8'h33);
    step();
    expect_eq("single_drained", bus.arb_htu_valid_o, 0);

    // Round-robin fairness, all channels streaming
    do_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      cnt[k] = 0;
      gcnt[k] = 0;
      bus.ch_req_valid_i[k] = 1'b1;
    end
    for (int c = 0; c < 14; c++) begin
      if (c >= 2) begin
        exp_ch = (c - 2) % NUM_CH;
        expect_eq("rr_valid", bus.arb_htu_valid_o, 1);
        expect_eq("rr_ch", bus.arb_htu_ch_id_o, exp_ch);
        expect_eq("rr_addr", bus.arb_htu_addr_o, (exp_ch << 8) | gcnt[exp_ch]);
        gcnt[exp_ch]++;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        set_req(k, 2'(k), 28'((k << 8) | cnt[k]), 8'(k));
        acc[k] = bus.ch_req_ready_o[k];
      end
      step();
      for (int k = 0; k < NUM_CH; k++) if (acc[k]) cnt[k]++;
    end

    // Backpressure on channel 0
    do_reset();
    bus.arb_htu_ready_i = 1'b0;
    cnt[0] = 0;
    for (int c = 0; c < 11; c++) begin
      if (c == 3) expect_eq("bp_ready_low", bus.ch_req_ready_o[0], 0);
      if (c >= 2) begin
        expect_eq("bp_hold_valid", bus.arb_htu_valid_o, 1);
        expect_eq("bp_hold_addr", bus.arb_htu_addr_o, 0);
      end
      bus.ch_req_valid_i[0] = 1'b1;
      set_req(0, 2'd2, 28'(cnt[0]), 8'h10);
      acc[0] = bus.ch_req_ready_o[0];
      step();
      if (acc[0]) cnt[0]++;
    end
    expect_eq("bp_accepts", cnt[0], 3);
    bus.ch_req_valid_i[0] = 1'b0;
    bus.arb_htu_ready_i = 1'b1;
    expect_eq("bp_drain0", bus.arb_htu_addr_o, 0);
    step();
    expect_eq("bp_drain1_valid", bus.arb_htu_valid_o, 1);
    expect_eq("bp_drain1", bus.arb_htu_addr_o, 1);
    step();
    expect_eq("bp_drain2_valid", bus.arb_htu_valid_o, 1);
    expect_eq("bp_drain2", bus.arb_htu_addr_o, 2);
    step();
    expect_eq("bp_empty", bus.arb_htu_valid_o, 0);

    // Credit exhaustion on channel 1
    do_reset();
    run_stream(1, 9, 20, 'h100, grants);
    expect_eq("cx_grants", grants, CRED_EN ? 8 : 9);
    expect_eq("cx_zero", bus.ch_credit_zero_o[1], CRED_EN);
    bus.xbar_rtn_valid_i = 1'b1;
    bus.xbar_rtn_ch_id_i = 2'd1;
    step();
    bus.xbar_rtn_valid_i = 1'b0;
    expect_eq("cx_zero_after_rtn", bus.ch_credit_zero_o[1], 0);
    expect_eq("cx_valid_pre", bus.arb_htu_valid_o, 0);
    step();
    expect_eq("cx_ninth_valid", bus.arb_htu_valid_o, CRED_EN);
    expect_eq("cx_ninth_addr", bus.arb_htu_addr_o, 'h108);
    expect_eq("cx_zero_again", bus.ch_credit_zero_o[1], CRED_EN);

    // Grant and return on channel 3 in the same cycle, then overflow return on channel 0
    do_reset();
    bus.ch_req_valid_i[3] = 1'b1;
    set_req(3, 2'd3, 28'h300, 8'h77);
    step();
    bus.ch_req_valid_i[3] = 1'b0;
    bus.xbar_rtn_valid_i = 1'b1;
    bus.xbar_rtn_ch_id_i = 2'd3;
    step();
    bus.xbar_rtn_valid_i = 1'b0;
    expect_eq("sim_valid", bus.arb_htu_valid_o, 1);
    expect_eq("sim_ch", bus.arb_htu_ch_id_o, 3);
    expect_eq("sim_err", bus.credit_err_o, 0);
    step();
    run_stream(3, 8, 16, 'h310, grants);
    expect_eq("sim_full_credit_grants", grants, 8);
    expect_eq("sim_zero", bus.ch_credit_zero_o[3], CRED_EN);
    expect_eq("sim_err_still0", bus.credit_err_o, 0);
    bus.xbar_rtn_valid_i = 1'b1;
    bus.xbar_rtn_ch_id_i = 2'd0;
    step();
    bus.xbar_rtn_valid_i = 1'b0;
    expect_eq("ovf_err", bus.credit_err_o, CRED_EN);
    step();
    step();
    expect_eq("ovf_err_sticky", bus.credit_err_o, CRED_EN);

    // Reset with all FIFOs full
    do_reset();
    bus.arb_htu_ready_i = 1'b0;
    bus.ch_req_valid_i = '1;
    for (int k = 0; k < NUM_CH; k++) set_req(k, 2'd1, 28'h5A5A5A5, 8'hEE);
    for (int c = 0; c < 6; c++) step();
    expect_eq("mr_full", bus.ch_req_ready_o, 0);
    expect_eq("mr_busy", bus.arb_htu_valid_o, 1);
    rst = 1'b1;
    #1;
    expect_eq("mr_valid", bus.arb_htu_valid_o, 0);
    expect_eq("mr_ready", bus.ch_req_ready_o, 4'hf);
    expect_eq("mr_addr", bus.arb_htu_addr_o, 0);
    expect_eq("mr_wbuf", bus.arb_htu_wbuffer_id_o, 0);
    idle_inputs();
    step();
    rst = 1'b0;
    bus.ch_req_valid_i[1] = 1'b1;
    set_req(1, 2'd2, 28'h0123456, 8'h5C);
    step();
    bus.ch_req_valid_i[1] = 1'b0;
    expect_eq("mr_lat_n1", bus.arb_htu_valid_o, 0);
    step();
    expect_eq("mr_lat_valid", bus.arb_htu_valid_o, 1);
    expect_eq("mr_lat_ch", bus.arb_htu_ch_id_o, 1);
    expect_eq("mr_lat_addr", bus.arb_htu_addr_o, 28'h0123456);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
